// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: ALU execute stage feeding a 2-entry writeback FIFO.
// Latency: 1 cycle from acceptance to out_valid when the FIFO is empty.
// Backpressure: in_ready drops when both slots are full; a pop reopens in_ready one cycle later.
//
// Ports:
//   clk, rst                : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready       : request handshake
//   in_a, in_b, in_aluop    : operands and opcode
//                             (AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111)
//   in_waddr                : destination register
//   out_valid/out_ready     : writeback handshake toward the register-file write port
//   out_wen, out_waddr      : write enable and address of the oldest entry
//   out_wdata, out_flags    : result and {Overflow, CarryOut, Zero} of the oldest entry
//   ovf_err                 : sticky overflow error
//
// Optional feature macro: ALU_OVF_TRAP_EN
//   defined   -> an ADD/SUB that overflows is stored with wen = 0 and sets ovf_err until rst
//   undefined -> overflow does not touch wen, ovf_err is tied to 0
//
// Flag semantics: Overflow and CarryOut come from the shared adder and are reported
// only for ADD and SUB (0 for all other opcodes). For SUB the adder computes
// a + ~b + 1, so CarryOut = 1 means "no borrow". Zero is (result == 0) for all opcodes.

module alu_exec_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_aluop,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wen,
  output logic [ADDR_WIDTH-1:0] out_waddr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [2:0]            out_flags,
  output logic                  ovf_err
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // One buffered writeback entry.
  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            flags;   // {Overflow, CarryOut, Zero}
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  aluop_e                op;
  logic                  sub_op;
  logic                  is_addsub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic                  ovf;
  logic                  lt_signed;
  logic                  lt_unsigned;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  trap_hit;
  entry_t                new_entry;

  assign op = aluop_e'(in_aluop);

  // SUB, SLT and SLTU all run the adder as a subtractor.
  assign sub_op    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign is_addsub = (op == OP_ADD) || (op == OP_SUB);

  assign b_eff   = sub_op ? ~in_b : in_b;
  assign sum_ext = {1'b0, in_a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_op};
  assign sum     = sum_ext[DATA_WIDTH-1:0];
  assign carry   = sum_ext[DATA_WIDTH];

  // Signed overflow: operands (after inversion) agree in sign, sum disagrees.
  assign ovf = (in_a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
               (sum[DATA_WIDTH-1]  != in_a[DATA_WIDTH-1]);

  // Signed compare corrects the difference sign by overflow; unsigned compare
  // is "borrow happened", i.e. no carry out of a + ~b + 1.
  assign lt_signed   = sum[DATA_WIDTH-1] ^ ovf;
  assign lt_unsigned = ~carry;

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_ADD:  result = sum;
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  result = in_a ^ in_b;
      OP_NOR:  result = ~(in_a | in_b);
      OP_SUB:  result = sum;
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVF_TRAP_EN
  assign trap_hit = is_addsub && ovf;
`else
  assign trap_hit = 1'b0;
`endif

  // Register 0 is hardwired to zero: the entry still flows but never writes.
  assign new_entry.wen   = (in_waddr != '0) && !trap_hit;
  assign new_entry.waddr = in_waddr;
  assign new_entry.wdata = result;
  assign new_entry.flags = {is_addsub & ovf, is_addsub & carry, zero};

  // ---------------------------------------------------------------------------
  // Occupancy FSM and pointers
  // ---------------------------------------------------------------------------
  state_e state;
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push;
  logic   pop;
  entry_t mem [2];

  // Both handshakes depend only on registered state, so out_ready never
  // reaches in_ready combinationally; a pop in TWO reopens in_ready next cycle.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= TWO;
          else if (pop && !push) state <= EMPTY;
        end
        TWO: if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Outputs present the oldest entry; forced to zero while empty so nothing
  // stale is visible after reset or drain.
  entry_t head;
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_wen   = head.wen;
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata;
  assign out_flags = head.flags;

  // ---------------------------------------------------------------------------
  // Sticky overflow error
  // ---------------------------------------------------------------------------
`ifdef ALU_OVF_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ovf_err <= 1'b0;
    else if (push && trap_hit) ovf_err <= 1'b1;
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 Parameter ADDR_WIDTH, default 5: destination register address width.
REQ-003 Single clock `clk`; reset `rst` is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  stage can accept a request.
REQ-008 in_a  input  DATA_WIDTH  operand A.
REQ-009 in_b  input  DATA_WIDTH  operand B.
REQ-010 in_aluop  input  3  ALU opcode: AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111.
REQ-011 in_waddr  input  ADDR_WIDTH  destination register.
REQ-012 out_valid  output  1  writeback entry valid.
REQ-013 out_ready  input  1  register-file write port accepts the entry.
REQ-014 out_wen  output  1  write enable for the entry.
REQ-015 out_waddr  output  ADDR_WIDTH  write address.
REQ-016 out_wdata  output  DATA_WIDTH  ALU result.
REQ-017 out_flags  output  3  {Overflow, CarryOut, Zero} for the entry.
REQ-018 ovf_err  output  1  sticky overflow error.

Function
REQ-019 Input transfer occurs on a rising edge with in_valid && in_ready; output transfer occurs on a rising edge with out_valid && out_ready.
REQ-020 Accepted operands are evaluated combinationally by the existing ALU in the same cycle; result, flags, waddr and wen are written into a 2-entry FIFO on that edge.
REQ-021 Latency: out_valid asserts on the cycle after acceptance when the FIFO was empty; no combinational path from in_* to out_*.
REQ-022 Occupancy FSM states: EMPTY, ONE, TWO; push-only advances one state, pop-only retreats one, push+pop holds.
REQ-023 in_ready = (state != TWO), derived from registered state only; no path from out_ready to in_ready.
REQ-024 In state TWO, a pop frees a slot; the next request is accepted on the following cycle, never on the pop cycle.
REQ-025 out_valid = (state != EMPTY); out_* show the oldest entry, held stable while out_valid && !out_ready.
REQ-026 FIFO read/write pointers are 1 bit and wrap 1->0; entries leave in acceptance order.
REQ-027 out_wen = 0 when waddr == 0 (hardwired zero register), else 1; the entry is still output and popped.
REQ-028 Zero flag equals (result == 0) for every opcode; Overflow and CarryOut are stored as produced by the ALU.

Reset
REQ-029 While rst is high: state EMPTY, both pointers 0, out_valid 0, in_ready 1, ovf_err 0, out_wen 0, out_waddr 0, out_wdata 0, out_flags 0.
REQ-030 Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro ALU_OVF_TRAP_EN: when defined, an accepted ADD or SUB with Overflow = 1 is stored with wen = 0 and sets ovf_err, which stays 1 until rst; when undefined, overflow does not affect wen and ovf_err is constant 0.

Verification
REQ-032 Reset release, then ADD a=5 b=7 waddr=3, out_ready=1 -> next cycle out_valid=1, wdata=12, wen=1, flags=000.
REQ-033 out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 after the second; raise out_ready -> outputs appear in order, third accepted one cycle after the first pop.
REQ-034 Full FIFO with in_valid=1 and out_ready=1 on the same cycle -> pop only, state TWO->ONE; next cycle push+pop holds ONE.
REQ-035 SUB a=3 b=3 waddr=0 -> wdata=0, Zero=1, wen=0, entry still popped.
REQ-036 ADD a=0x7FFFFFFF b=1 waddr=4 -> Overflow=1; with ALU_OVF_TRAP_EN: wen=0 and ovf_err=1 until rst; without it: wen=1 and ovf_err=0.
REQ-037 rst pulsed with 2 entries buffered -> out_valid=0 immediately, in_ready=1, no stale entry after release.
